// File: rtl/val2_pkg.sv
// Shared constants for the operand-2 generator: shift type codes and the
// bit positions of the fields inside the 12-bit shifter-operand.
package val2_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int IMM8_LSB  = 0;
  localparam int IMM8_MSB  = 7;
  localparam int ROT_LSB   = 8;
  localparam int ROT_MSB   = 11;
  localparam int SHAMT_LSB = 7;
  localparam int SHAMT_MSB = 11;
  localparam int TYPE_LSB  = 5;
  localparam int TYPE_MSB  = 6;

  // Wide enough for Rs[7:0] and for DATA_W itself (up to 64).
  localparam int AMT_W = 9;

endpackage

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter: LSL/LSR/ASR/ROR by a pre-decoded amount, plus
// RRX, producing the result and the last bit shifted out.
module val2_shift_core
  import val2_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] i_rm,
  input  logic              i_carryIn,
  input  logic [AMT_W-1:0]  i_amount,
  input  logic [1:0]        i_shiftType,
  input  logic              i_rrx,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  localparam logic [AMT_W-1:0] FULL_AMT = AMT_W'(DATA_W);

  logic [DATA_W:0]        w_lslFull;
  logic [DATA_W:0]        w_lsrFull;
  logic signed [DATA_W:0] w_asrFull;
  logic [AMT_W-1:0]       w_asrAmt;
  logic [DATA_W-1:0]      w_rorResult;

  // One extra bit beside the operand catches the carry; large amounts
  // naturally shift everything (carry included) out to zero.
  assign w_lslFull   = {1'b0, i_rm} << i_amount;
  assign w_lsrFull   = {i_rm, 1'b0} >> i_amount;
  assign w_asrAmt    = (i_amount > FULL_AMT) ? FULL_AMT : i_amount;
  assign w_asrFull   = $signed({i_rm, 1'b0}) >>> w_asrAmt;
  assign w_rorResult = DATA_W'({i_rm, i_rm} >> i_amount[SHAMT_W-1:0]);

  always_comb begin
    o_result = i_rm;
    o_carry  = i_carryIn;
    if (i_rrx) begin
      o_result = {i_carryIn, i_rm[DATA_W-1:1]};
      o_carry  = i_rm[0];
    end else if (i_amount != '0) begin
      case (i_shiftType)
        SH_LSL:  {o_carry, o_result} = w_lslFull;
        SH_LSR:  {o_result, o_carry} = w_lsrFull;
        SH_ASR:  {o_result, o_carry} = w_asrFull;
        default: begin
          // A rotate's last bit out always lands in the result MSB.
          o_result = w_rorResult;
          o_carry  = w_rorResult[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_pipe.sv
// EXE-stage operand-2 generator: decodes the shifter-operand field, runs the
// shift core and registers the result behind a valid/ready pipeline.
module val2_shift_pipe
  import val2_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  PIPE_STAGES = 1,
  localparam int SHAMT_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic [11:0]       shift_operand,
  input  logic              immediate,
  input  logic              reg_shift,
  input  logic              is_mem,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              shift_carry,
  output logic              busy
);

  logic [DATA_W-1:0] w_decOperand;
  logic [AMT_W-1:0]  w_decAmount;
  logic [1:0]        w_decType;
  logic              w_decRrx;

  logic [DATA_W-1:0] w_coreOperand;
  logic [AMT_W-1:0]  w_coreAmount;
  logic [1:0]        w_coreType;
  logic              w_coreRrx;
  logic              w_coreCarryIn;
  logic [DATA_W-1:0] w_coreResult;
  logic              w_coreCarry;

  logic              r_outValid;
  logic [DATA_W-1:0] r_val2;
  logic              r_shiftCarry;
  logic              w_outReady;
  logic              w_outLoad;
  logic              w_stageBusy;
  logic              w_unusedRsBits;

  assign w_unusedRsBits = ^rs[DATA_W-1:8];

  // Every mode is reduced to (operand, amount, type, rrx); amount 0 means
  // pass the operand through with carry_in, which covers is_mem and LSL #0.
  always_comb begin
    w_decOperand = rm;
    w_decAmount  = '0;
    w_decType    = SH_LSL;
    w_decRrx     = 1'b0;
    if (is_mem) begin
      w_decOperand = {{(DATA_W-12){1'b0}}, shift_operand};
    end else if (immediate) begin
      w_decOperand = {{(DATA_W-8){1'b0}}, shift_operand[IMM8_MSB:IMM8_LSB]};
      w_decAmount  = {4'b0, shift_operand[ROT_MSB:ROT_LSB], 1'b0};
      w_decType    = SH_ROR;
    end else if (reg_shift) begin
      w_decAmount  = {1'b0, rs[7:0]};
      w_decType    = shift_operand[TYPE_MSB:TYPE_LSB];
    end else begin
      w_decType    = shift_operand[TYPE_MSB:TYPE_LSB];
      w_decAmount  = {4'b0, shift_operand[SHAMT_MSB:SHAMT_LSB]};
      if (shift_operand[SHAMT_MSB:SHAMT_LSB] == 5'd0) begin
        case (shift_operand[TYPE_MSB:TYPE_LSB])
          SH_LSR, SH_ASR: w_decAmount = AMT_W'(DATA_W);
          SH_ROR:         w_decRrx    = 1'b1;
          default:        w_decAmount = '0;
        endcase
      end
    end
  end

  assign w_outReady = !r_outValid || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_twoStage
      logic              r_s1Valid;
      logic [DATA_W-1:0] r_s1Operand;
      logic [AMT_W-1:0]  r_s1Amount;
      logic [1:0]        r_s1Type;
      logic              r_s1Rrx;
      logic              r_s1CarryIn;

      assign in_ready = !r_s1Valid || w_outReady;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1Valid   <= 1'b0;
          r_s1Operand <= '0;
          r_s1Amount  <= '0;
          r_s1Type    <= SH_LSL;
          r_s1Rrx     <= 1'b0;
          r_s1CarryIn <= 1'b0;
        end else begin
          if (in_ready) r_s1Valid <= in_valid;
          if (in_valid && in_ready) begin
            r_s1Operand <= w_decOperand;
            r_s1Amount  <= w_decAmount;
            r_s1Type    <= w_decType;
            r_s1Rrx     <= w_decRrx;
            r_s1CarryIn <= carry_in;
          end
        end
      end

      assign w_coreOperand = r_s1Operand;
      assign w_coreAmount  = r_s1Amount;
      assign w_coreType    = r_s1Type;
      assign w_coreRrx     = r_s1Rrx;
      assign w_coreCarryIn = r_s1CarryIn;
      assign w_outLoad     = r_s1Valid && w_outReady;
      assign w_stageBusy   = r_s1Valid;
    end else begin : g_oneStage
      assign in_ready      = w_outReady;
      assign w_coreOperand = w_decOperand;
      assign w_coreAmount  = w_decAmount;
      assign w_coreType    = w_decType;
      assign w_coreRrx     = w_decRrx;
      assign w_coreCarryIn = carry_in;
      assign w_outLoad     = in_valid && in_ready;
      assign w_stageBusy   = 1'b0;
    end
  endgenerate

  val2_shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .i_rm        (w_coreOperand),
    .i_carryIn   (w_coreCarryIn),
    .i_amount    (w_coreAmount),
    .i_shiftType (w_coreType),
    .i_rrx       (w_coreRrx),
    .o_result    (w_coreResult),
    .o_carry     (w_coreCarry)
  );

  // Data only loads on a transfer, so a stalled result holds still.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_val2       <= '0;
      r_shiftCarry <= 1'b0;
    end else begin
      if (w_outReady) r_outValid <= w_outLoad;
      if (w_outLoad) begin
        r_val2       <= w_coreResult;
        r_shiftCarry <= w_coreCarry;
      end
    end
  end

  assign out_valid   = r_outValid;
  assign val2        = r_val2;
  assign shift_carry = r_shiftCarry;
  assign busy        = r_outValid || w_stageBusy;

endmodule

// File: tb/tb_val2_shift_pipe.sv
// Scoreboard bench for val2_shift_pipe: a 32-bit two-stage instance and a
// 16-bit single-stage instance checked against a bit-level reference model.
module tb_val2_shift_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        aInValid, aInReady, aImm, aRegShift, aIsMem, aCarryIn;
  logic        aOutValid, aOutReady, aShiftCarry, aBusy;
  logic [31:0] aRm, aRs, aVal2;
  logic [11:0] aShiftOp;

  logic        bInValid, bInReady, bImm, bRegShift, bIsMem, bCarryIn;
  logic        bOutValid, bOutReady, bShiftCarry, bBusy;
  logic [15:0] bRm, bRs, bVal2;
  logic [11:0] bShiftOp;

  logic [64:0] qA[$];
  logic [64:0] qB[$];
  int          compared;
  int          mismatched;
  int          acceptA;
  bit          randDone;

  val2_shift_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(aInValid), .in_ready(aInReady),
    .rm(aRm), .rs(aRs), .shift_operand(aShiftOp), .immediate(aImm),
    .reg_shift(aRegShift), .is_mem(aIsMem), .carry_in(aCarryIn),
    .out_valid(aOutValid), .out_ready(aOutReady), .val2(aVal2),
    .shift_carry(aShiftCarry), .busy(aBusy)
  );

  val2_shift_pipe #(.DATA_W(16), .PIPE_STAGES(1)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(bInValid), .in_ready(bInReady),
    .rm(bRm), .rs(bRs), .shift_operand(bShiftOp), .immediate(bImm),
    .reg_shift(bRegShift), .is_mem(bIsMem), .carry_in(bCarryIn),
    .out_valid(bOutValid), .out_ready(bOutReady), .val2(bVal2),
    .shift_carry(bShiftCarry), .busy(bBusy)
  );

  // Reference model working bit by bit from the ARM shifter rules; returns
  // {carry, value} with value confined to the low w bits.
  function automatic logic [64:0] refModel(input int w, input logic [63:0] rm,
                                           input logic [7:0] rs8, input logic [11:0] so,
                                           input logic imm, input logic regs,
                                           input logic mem, input logic cin);
    logic [63:0] v;
    logic [63:0] imm64;
    logic        c;
    int          amt;
    int          r;
    int          kind;
    v    = '0;
    c    = cin;
    kind = int'(so[6:5]);
    if (mem) begin
      v[11:0] = so;
    end else if (imm) begin
      imm64 = {56'd0, so[7:0]};
      r = (2 * int'(so[11:8])) % w;
      for (int i = 0; i < w; i++) v[i] = imm64[(i + r) % w];
      if (so[11:8] != 4'd0) c = v[w-1];
    end else begin
      if (regs) amt = int'(rs8);
      else begin
        amt = int'(so[11:7]);
        if (amt == 0 && (kind == 1 || kind == 2)) amt = w;
      end
      if (!regs && amt == 0 && kind == 3) begin
        for (int i = 0; i < w - 1; i++) v[i] = rm[i+1];
        v[w-1] = cin;
        c = rm[0];
      end else if (amt == 0) begin
        v = rm;
      end else begin
        case (kind)
          0: begin
            for (int i = 0; i < w; i++) v[i] = (i >= amt) ? rm[i-amt] : 1'b0;
            c = (amt <= w) ? rm[w-amt] : 1'b0;
          end
          1: begin
            for (int i = 0; i < w; i++) v[i] = (i + amt < w) ? rm[i+amt] : 1'b0;
            c = (amt <= w) ? rm[amt-1] : 1'b0;
          end
          2: begin
            for (int i = 0; i < w; i++) v[i] = (i + amt < w) ? rm[i+amt] : rm[w-1];
            c = (amt <= w) ? rm[amt-1] : rm[w-1];
          end
          default: begin
            r = amt % w;
            for (int i = 0; i < w; i++) v[i] = rm[(i + r) % w];
            c = rm[(r + w - 1) % w];
          end
        endcase
      end
    end
    return {c, v};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request (called at posedge+1), holds it until accepted and
  // pushes the model's answer at the cycle the transfer is seen.
  task automatic applyStimulus(input int which, input logic [63:0] rm, input logic [63:0] rs,
                               input logic [11:0] so, input logic imm, input logic regs,
                               input logic mem, input logic cin);
    int          w;
    logic [63:0] rmMask;
    logic [64:0] exp;
    bit          accepted;
    w        = (which == 0) ? 32 : 16;
    rmMask   = rm & ((64'd1 << w) - 64'd1);
    exp      = refModel(w, rmMask, rs[7:0], so, imm, regs, mem, cin);
    accepted = 1'b0;
    if (which == 0) begin
      aRm = rm[31:0]; aRs = rs[31:0]; aShiftOp = so; aImm = imm;
      aRegShift = regs; aIsMem = mem; aCarryIn = cin; aInValid = 1'b1;
    end else begin
      bRm = rm[15:0]; bRs = rs[15:0]; bShiftOp = so; bImm = imm;
      bRegShift = regs; bIsMem = mem; bCarryIn = cin; bInValid = 1'b1;
    end
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (((which == 0) ? aInReady : bInReady) == 1'b1) begin
        accepted = 1'b1;
        if (which == 0) begin
          qA.push_back(exp);
          acceptA++;
        end else begin
          qB.push_back(exp);
        end
      end
      @(posedge clk);
      #1;
    end
    if (which == 0) aInValid = 1'b0;
    else            bInValid = 1'b0;
    if (!accepted) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept timeout dut%0d: in_ready never rose within 200 cycles", which);
    end
  endtask

  task automatic randomTxn(input int which);
    int          w;
    logic [63:0] rm;
    logic [63:0] rs;
    logic [11:0] so;
    w  = (which == 0) ? 32 : 16;
    rm = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: rm = (64'd1 << (w - 1)) | 64'd1;
      1: rm = '1;
      default: ;
    endcase
    rs = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: rs[7:0] = 8'd0;
      1: rs[7:0] = 8'(w);
      2: rs[7:0] = 8'(w + 1);
      3: rs[7:0] = 8'(w - 1);
      default: ;
    endcase
    so = 12'($urandom);
    if ($urandom_range(0, 4) == 0) so[11:7] = 5'd0;
    applyStimulus(which, rm, rs, so, $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom_range(0, 7) == 0, 1'($urandom));
  endtask

  task automatic runRandom(input int which, input int count);
    randDone = 1'b0;
    fork
      begin
        for (int k = 0; k < count; k++) randomTxn(which);
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          if (which == 0) aOutReady = ($urandom_range(0, 3) != 0);
          else            bOutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    aOutReady = 1'b1;
    bOutReady = 1'b1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (qA.size() != 0 || qB.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain timeout: %0d/%0d results still owed", qA.size(), qB.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Every presented output (stalled or not) must match the oldest expectation.
  always @(negedge clk) begin : monitorA
    logic [64:0] e;
    if (rst_n && aOutValid) begin
      if (qA.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL A unexpected output: val2=0x%0h with no request outstanding", aVal2);
      end else begin
        e = qA[0];
        checkOutput("A val2", 64'(aVal2), e[63:0]);
        checkOutput("A shift_carry", 64'(aShiftCarry), 64'(e[64]));
        if (aOutReady) void'(qA.pop_front());
      end
    end
  end

  always @(negedge clk) begin : monitorB
    logic [64:0] e;
    if (rst_n && bOutValid) begin
      if (qB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL B unexpected output: val2=0x%0h with no request outstanding", bVal2);
      end else begin
        e = qB[0];
        checkOutput("B val2", 64'(bVal2), e[63:0]);
        checkOutput("B shift_carry", 64'(bShiftCarry), 64'(e[64]));
        if (bOutReady) void'(qB.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    compared = 0; mismatched = 0; acceptA = 0; randDone = 1'b0;
    aInValid = 0; aRm = 0; aRs = 0; aShiftOp = 0; aImm = 0; aRegShift = 0;
    aIsMem = 0; aCarryIn = 0; aOutReady = 1;
    bInValid = 0; bRm = 0; bRs = 0; bShiftOp = 0; bImm = 0; bRegShift = 0;
    bIsMem = 0; bCarryIn = 0; bOutReady = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset A out_valid", 64'(aOutValid), 64'd0);
    checkOutput("reset A val2", 64'(aVal2), 64'd0);
    checkOutput("reset A shift_carry", 64'(aShiftCarry), 64'd0);
    checkOutput("reset A busy", 64'(aBusy), 64'd0);
    checkOutput("reset B out_valid", 64'(bOutValid), 64'd0);
    checkOutput("reset B busy", 64'(bBusy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("A in_ready after reset", 64'(aInReady), 64'd1);
    checkOutput("B in_ready after reset", 64'(bInReady), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases on the 32-bit instance.
    applyStimulus(0, 64'h0, 64'h0, 12'h4FF, 1, 0, 0, 0);
    applyStimulus(0, 64'h0, 64'h0, 12'h0FF, 1, 0, 0, 1);
    applyStimulus(0, 64'h80000001, 64'h0, 12'h020, 0, 0, 0, 0);
    applyStimulus(0, 64'h80000001, 64'h0, 12'h040, 0, 0, 0, 0);
    applyStimulus(0, 64'h80000001, 64'h0, 12'h060, 0, 0, 0, 0);
    applyStimulus(0, 64'h80000001, 64'd32, 12'h010, 0, 1, 0, 0);
    applyStimulus(0, 64'h80000001, 64'd33, 12'h010, 0, 1, 0, 1);
    applyStimulus(0, 64'h80000001, 64'd32, 12'h070, 0, 1, 0, 0);
    applyStimulus(0, 64'h80000001, 64'h100, 12'h030, 0, 1, 0, 1);
    applyStimulus(0, 64'h12345678, 64'h0, 12'hFFF, 1, 0, 1, 0);
    applyStimulus(0, 64'h12345678, 64'h0, 12'h200, 0, 0, 0, 0);
    applyStimulus(1, 64'h0, 64'h0, 12'h4FF, 1, 0, 0, 0);
    applyStimulus(1, 64'h0, 64'h0, 12'h0FF, 1, 0, 0, 1);
    applyStimulus(1, 64'h8001, 64'd16, 12'h010, 0, 1, 0, 0);
    waitDrain();

    // Back-pressure: two entries fit while the consumer stalls.
    aOutReady = 1'b0;
    base = acceptA;
    fork
      begin
        for (int k = 0; k < 4; k++)
          applyStimulus(0, {$urandom, $urandom}, {$urandom, $urandom}, 12'($urandom),
                        1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp accepted while stalled", 64'(acceptA - base), 64'd2);
        checkOutput("bp in_ready while full", 64'(aInReady), 64'd0);
        checkOutput("bp busy while full", 64'(aBusy), 64'd1);
        @(posedge clk);
        #1 aOutReady = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp all four delivered", 64'(acceptA - base), 64'd4);

    runRandom(0, 250);
    waitDrain();
    runRandom(1, 150);
    waitDrain();

    // Reset while results are waiting: they must vanish and never reappear.
    aOutReady = 1'b0;
    bOutReady = 1'b0;
    applyStimulus(0, 64'h80000001, 64'h0, 12'h020, 0, 0, 0, 0);
    applyStimulus(1, 64'h8001, 64'h0, 12'h040, 0, 0, 0, 0);
    for (int n = 0; n < 10 && !(aOutValid && bOutValid); n++) @(negedge clk);
    checkOutput("A out_valid before reset", 64'(aOutValid), 64'd1);
    checkOutput("B out_valid before reset", 64'(bOutValid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("A out_valid in reset", 64'(aOutValid), 64'd0);
    checkOutput("B out_valid in reset", 64'(bOutValid), 64'd0);
    checkOutput("A busy in reset", 64'(aBusy), 64'd0);
    qA.delete();
    qB.delete();
    repeat (2) @(posedge clk);
    #1;
    aOutReady = 1'b1;
    bOutReady = 1'b1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("A out_valid after reset", 64'(aOutValid), 64'd0);
      checkOutput("B out_valid after reset", 64'(bOutValid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
